// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs {op, Rt, Rn, immediate} into a 32-bit LEGv8 word (LDUR, STUR, CBZ).
//   Immediates that do not fit the instruction field are rejected.
//   Requests come in and words go out on valid/ready streams. There is a
//   single output register stage between them. Each good word carries a
//   sequential word address.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request valid
//   in_ready   encoder can accept a request this cycle
//   in_op      0=LDUR 1=STUR 2=CBZ 3=undefined
//   in_rt      Rt field
//   in_rn      Rn field (ignored for CBZ)
//   in_imm     byte offset, two's complement, REGLEN bits
//   out_valid  out_instr/out_addr/out_err valid
//   out_ready  consumer accepts the output word
//   out_instr  encoded instruction (0 when out_err)
//   out_addr   word address of out_instr
//   out_err    request was unencodable
//   err_cnt    saturating count of errored requests
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid & ready are both high. The producer holds valid and the
// payload stable until that transfer. ready may depend combinationally on
// the downstream ready: in_ready = !out_valid | out_ready. This lets the
// encoder accept a new request and drain the old word in the same cycle.
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int REGLEN = 64,
  parameter int ADDRW  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rn,
  input  logic [REGLEN-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDRW-1:0]  out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [1:0] OP_LDUR = 2'd0;
  localparam logic [1:0] OP_STUR = 2'd1;
  localparam logic [1:0] OP_CBZ  = 2'd2;

  // Output register occupancy. out_valid is this state.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               init_q;
  logic [31:0]        instr_q;
  logic [ADDRW-1:0]   addr_q;
  logic               err_q;
  logic [7:0]         err_cnt_q;
  logic [ADDRW-1:0]   addr_cnt_q;

  logic               in_xfer;
  logic               out_xfer;
  logic               ls_fit;
  logic               cbz_fit;
  logic               enc_err;
  logic [31:0]        enc_instr;

  // ------------------------------------------------------------------------
  // Encoding and range check (purely combinational on the request)
  // ------------------------------------------------------------------------
  // The immediate fits a field when all bits above the field's sign bit
  // copy that sign bit.
  assign ls_fit  = (&in_imm[REGLEN-1:8])  | ~(|in_imm[REGLEN-1:8]);
  assign cbz_fit = ((&in_imm[REGLEN-1:20]) | ~(|in_imm[REGLEN-1:20])) &&
                   (in_imm[1:0] == 2'b00);

  always_comb begin
    enc_err   = 1'b1;
    enc_instr = 32'h0;
    case (in_op)
      OP_LDUR: begin
        enc_err   = !ls_fit;
        enc_instr = {11'b111_1100_0010, in_imm[8:0], 2'b00, in_rn, in_rt};
      end
      OP_STUR: begin
        enc_err   = !ls_fit;
        enc_instr = {11'b111_1100_0000, in_imm[8:0], 2'b00, in_rn, in_rt};
      end
      OP_CBZ: begin
        enc_err   = !cbz_fit;
        enc_instr = {8'b1011_0100, in_imm[20:2], in_rt};
      end
      default: begin
        enc_err   = 1'b1;
        enc_instr = 32'h0;
      end
    endcase
    if (enc_err) enc_instr = 32'h0;
  end

  // ------------------------------------------------------------------------
  // Output register FSM
  // ------------------------------------------------------------------------
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_xfer) state_d = FULL;
      FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output logic. init_q holds in_ready low through reset and for the
  // first edge after release.
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = init_q & (!out_valid | out_ready);
  end

  // ------------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q     <= 1'b0;
      instr_q    <= 32'h0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h0;
      addr_cnt_q <= '0;
    end else begin
      init_q <= 1'b1;
      if (in_xfer) begin
        instr_q <= enc_instr;
        addr_q  <= addr_cnt_q;
        err_q   <= enc_err;
        // A rejected request leaves the address free for the next good word.
        if (enc_err) begin
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
          addr_cnt_q <= addr_cnt_q + ADDRW'(1);
        end
      end
    end
  end

  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int REGLEN = 64;
  localparam int ADDRW  = 2;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [4:0]        in_rt;
  logic [4:0]        in_rn;
  logic [REGLEN-1:0] in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDRW-1:0]  out_addr;
  logic              out_err;
  logic [7:0]        err_cnt;

  int n_vec;
  int n_err;

  instr_encoder #(.REGLEN(REGLEN), .ADDRW(ADDRW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rt     (in_rt),
    .in_rn     (in_rn),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic send(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn,
                      input logic [63:0] imm);
    int t;
    in_op    = op;
    in_rt    = rt;
    in_rn    = rn;
    in_imm   = imm;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr,
                             input logic [ADDRW-1:0] addr, input logic err);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_addr"},  32'(out_addr), 32'(addr));
    chk({tag, "_err"},   32'(out_err), 32'(err));
  endtask

  // Drain the held word in one cycle.
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_rt     = 5'd0;
    in_rn     = 5'd0;
    in_imm    = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_instr",   out_instr, 32'h0);
    chk("rst_addr",    32'(out_addr), 32'd0);
    chk("rst_err",     32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: LDUR rt=1 rn=2 imm=-8
    send(2'd0, 5'd1, 5'd2, -64'sd8);
    expect_word("ldur_neg8", 32'hF85F8041, 2'd0, 1'b0);
    take();

    // 2: CBZ rt=3 imm=+16 then -4
    send(2'd2, 5'd3, 5'd0, 64'sd16);
    expect_word("cbz_p16", 32'hB4000083, 2'd1, 1'b0);
    take();
    send(2'd2, 5'd3, 5'd0, -64'sd4);
    expect_word("cbz_m4", 32'hB4FFFFE3, 2'd2, 1'b0);
    take();

    // 3: errors do not advance the address
    send(2'd0, 5'd1, 5'd2, 64'sd256);
    expect_word("ldur_256", 32'h0, 2'd3, 1'b1);
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    take();
    send(2'd2, 5'd1, 5'd0, 64'sd6);
    expect_word("cbz_6", 32'h0, 2'd3, 1'b1);
    chk("err_cnt_2", 32'(err_cnt), 32'd2);
    take();
    send(2'd3, 5'd1, 5'd2, 64'sd0);
    expect_word("op3", 32'h0, 2'd3, 1'b1);
    chk("err_cnt_3", 32'(err_cnt), 32'd3);
    take();
    send(2'd1, 5'd5, 5'd6, 64'sd255);
    expect_word("stur_255", 32'hF80FF0C5, 2'd3, 1'b0);
    take();
    // Range boundaries; address wraps 3 -> 0
    send(2'd0, 5'd0, 5'd0, -64'sd256);
    expect_word("ldur_m256", 32'hF8500000, 2'd0, 1'b0);
    take();
    send(2'd2, 5'd0, 5'd0, 64'sd1048572);
    expect_word("cbz_max", 32'hB47FFFE0, 2'd1, 1'b0);
    take();
    send(2'd2, 5'd0, 5'd0, 64'sd1048576);
    expect_word("cbz_over", 32'h0, 2'd2, 1'b1);
    chk("err_cnt_4", 32'(err_cnt), 32'd4);
    take();
    send(2'd2, 5'd0, 5'd0, -64'sd1048576);
    expect_word("cbz_min", 32'hB4800000, 2'd2, 1'b0);
    take();

    // 4: back-pressure holds the word and blocks the input
    send(2'd0, 5'd1, 5'd2, -64'sd8);
    in_op = 2'd1; in_rt = 5'd2; in_rn = 5'd3; in_imm = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      expect_word("stall_hold", 32'hF85F8041, 2'd3, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_word("stall_next", 32'hF8000062, 2'd0, 1'b0);
    @(posedge clk); #1;
    chk("stall_drained", 32'(out_valid), 32'd0);

    // 5: streaming at one word per cycle, address wrap
    for (int k = 1; k <= 5; k++) begin
      in_op = 2'd2; in_rt = 5'(k); in_rn = 5'd0; in_imm = '0;
      in_valid = 1'b1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      expect_word("stream", 32'hB4000000 | 32'(k), 2'(k % 4), 1'b0);
    end

    // Error counter saturation: 260 more errors on top of 4
    in_op = 2'd3;
    for (int k = 0; k < 260; k++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    expect_word("sat", 32'h0, 2'd2, 1'b1);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'd2, 5'd7, 5'd0, 64'sd8);
    expect_word("after_sat", 32'hB4000047, 2'd2, 1'b0);

    // 6: async reset while a word is held
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid",   32'(out_valid), 32'd0);
    chk("arst_addr",    32'(out_addr), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_instr",   out_instr, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    send(2'd0, 5'd1, 5'd2, -64'sd8);
    expect_word("arst_first", 32'hF85F8041, 2'd0, 1'b0);
    take();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
